// File: rtl/health_manager.sv
// rtl/health_manager.sv - per-player health, hit acceptance, bar drain and round state
// Displayed health drains toward the true target one step per frame; the round ends once both bars settle.
module health_manager #(
   parameter int MAX_HEALTH    = 200,
   parameter int DRAIN_STEP    = 2,
   parameter int INVULN_FRAMES = 30
) (
   input  logic       vga_clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic       round_start,
   input  logic       ryu_hit,
   input  logic [7:0] ryu_dmg,
   input  logic       akuma_hit,
   input  logic [7:0] akuma_dmg,
   output logic       ryu_hit_acc,
   output logic       akuma_hit_acc,
   output logic [7:0] RyuHealth,
   output logic [7:0] AkumaHealth,
   output logic       ko,
   output logic [1:0] winner
);

   localparam int INV_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
   localparam logic [7:0]       FULL     = 8'(MAX_HEALTH);
   localparam logic [7:0]       STEP     = 8'(DRAIN_STEP);
   localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INVULN_FRAMES);

   typedef enum logic [1:0] {IDLE, FIGHT, FINISH, KO_S} state_t;

   state_t           state_q, state_d;
   logic [7:0]       ryu_tgt, ryu_tgt_d, akuma_tgt, akuma_tgt_d;
   logic [7:0]       ryu_disp_d, akuma_disp_d;
   logic [INV_W-1:0] ryu_inv, ryu_inv_d, akuma_inv, akuma_inv_d;
   logic             ryu_acc_d, akuma_acc_d, ko_d;
   logic [1:0]       winner_d;
   logic             ryu_ok, akuma_ok, live;

   // Step the bar down by at most STEP without passing the target.
   function automatic logic [7:0] drain(input logic [7:0] d, input logic [7:0] t);
      logic [7:0] diff;
      diff = d - t;
      return (diff > STEP) ? d - STEP : t;
   endfunction

   function automatic logic [7:0] sat_sub(input logic [7:0] t, input logic [7:0] dmg);
      return (t > dmg) ? t - dmg : 8'd0;
   endfunction

   assign live     = (state_q == FIGHT) || (state_q == FINISH);
   assign ryu_ok   = (state_q == FIGHT) && ryu_hit && (ryu_dmg != 8'd0) && (ryu_inv == '0);
   assign akuma_ok = (state_q == FIGHT) && akuma_hit && (akuma_dmg != 8'd0) && (akuma_inv == '0);

   always_comb begin
      state_d      = state_q;
      ryu_tgt_d    = ryu_tgt;
      akuma_tgt_d  = akuma_tgt;
      ryu_disp_d   = RyuHealth;
      akuma_disp_d = AkumaHealth;
      ryu_inv_d    = ryu_inv;
      akuma_inv_d  = akuma_inv;
      ryu_acc_d    = 1'b0;
      akuma_acc_d  = 1'b0;
      winner_d     = winner;

      if (round_start) begin
         state_d      = FIGHT;
         ryu_tgt_d    = FULL;
         akuma_tgt_d  = FULL;
         ryu_disp_d   = FULL;
         akuma_disp_d = FULL;
         ryu_inv_d    = '0;
         akuma_inv_d  = '0;
         winner_d     = 2'b00;
      end else begin
         // Tick uses the pre-hit targets; a same-cycle hit load below overrides the decrement.
         if (live && frame_tick) begin
            ryu_disp_d   = drain(RyuHealth, ryu_tgt);
            akuma_disp_d = drain(AkumaHealth, akuma_tgt);
            if (ryu_inv != '0)   ryu_inv_d   = ryu_inv - 1'b1;
            if (akuma_inv != '0) akuma_inv_d = akuma_inv - 1'b1;
         end
         if (ryu_ok) begin
            ryu_tgt_d = sat_sub(ryu_tgt, ryu_dmg);
            ryu_inv_d = INV_LOAD;
            ryu_acc_d = 1'b1;
         end
         if (akuma_ok) begin
            akuma_tgt_d = sat_sub(akuma_tgt, akuma_dmg);
            akuma_inv_d = INV_LOAD;
            akuma_acc_d = 1'b1;
         end

         case (state_q)
            FIGHT: begin
               if ((ryu_tgt_d == 8'd0) || (akuma_tgt_d == 8'd0)) state_d = FINISH;
            end
            FINISH: begin
               if ((RyuHealth == ryu_tgt) && (AkumaHealth == akuma_tgt)) begin
                  state_d  = KO_S;
                  // A zero Ryu target means Akuma won (10), and vice versa (01).
                  winner_d = {ryu_tgt == 8'd0, akuma_tgt == 8'd0};
               end
            end
            default: state_d = state_q;
         endcase
      end

      ko_d = (state_d == KO_S);
   end

   always_ff @(posedge vga_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= IDLE;
         ryu_tgt       <= FULL;
         akuma_tgt     <= FULL;
         RyuHealth     <= FULL;
         AkumaHealth   <= FULL;
         ryu_inv       <= '0;
         akuma_inv     <= '0;
         ryu_hit_acc   <= 1'b0;
         akuma_hit_acc <= 1'b0;
         ko            <= 1'b0;
         winner        <= 2'b00;
      end else begin
         state_q       <= state_d;
         ryu_tgt       <= ryu_tgt_d;
         akuma_tgt     <= akuma_tgt_d;
         RyuHealth     <= ryu_disp_d;
         AkumaHealth   <= akuma_disp_d;
         ryu_inv       <= ryu_inv_d;
         akuma_inv     <= akuma_inv_d;
         ryu_hit_acc   <= ryu_acc_d;
         akuma_hit_acc <= akuma_acc_d;
         ko            <= ko_d;
         winner        <= winner_d;
      end
   end

endmodule

// File: tb/tb_health_manager.sv
// tb/tb_health_manager.sv - self-checking bench for health_manager
// Vectors are queued with their expected outputs and compared after the clock edge.
module tb_health_manager;

   logic       vga_clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_tick = 1'b0, round_start = 1'b0;
   logic       ryu_hit = 1'b0, akuma_hit = 1'b0;
   logic [7:0] ryu_dmg = 8'd0, akuma_dmg = 8'd0;
   logic       ryu_hit_acc, akuma_hit_acc, ko;
   logic [7:0] RyuHealth, AkumaHealth;
   logic [1:0] winner;

   health_manager dut (
      .vga_clk(vga_clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .round_start(round_start),
      .ryu_hit(ryu_hit), .ryu_dmg(ryu_dmg), .akuma_hit(akuma_hit), .akuma_dmg(akuma_dmg),
      .ryu_hit_acc(ryu_hit_acc), .akuma_hit_acc(akuma_hit_acc),
      .RyuHealth(RyuHealth), .AkumaHealth(AkumaHealth), .ko(ko), .winner(winner)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      logic       tick, rs, rh;
      logic [7:0] rd;
      logic       ah;
      logic [7:0] ad;
      logic       e_racc, e_aacc;
      logic [7:0] e_rh, e_ah;
      logic       e_ko;
      logic [1:0] e_win;
   } vec_t;

   int    total = 0;
   int    bad = 0;
   vec_t  exp_q[$];
   string name_q[$];

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic vec_t mk(input logic tick, input logic rs, input logic rh, input int rd,
                               input logic ah, input int ad, input logic eracc, input logic eaacc,
                               input int erh, input int eah, input logic eko, input int ew);
      vec_t v;
      v.tick = tick; v.rs = rs; v.rh = rh; v.rd = 8'(rd); v.ah = ah; v.ad = 8'(ad);
      v.e_racc = eracc; v.e_aacc = eaacc; v.e_rh = 8'(erh); v.e_ah = 8'(eah);
      v.e_ko = eko; v.e_win = 2'(ew);
      return v;
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_out;
      vec_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      cmp({nm, ".ryu_acc"}, ryu_hit_acc, e.e_racc);
      cmp({nm, ".akuma_acc"}, akuma_hit_acc, e.e_aacc);
      cmp({nm, ".ryu_health"}, RyuHealth, e.e_rh);
      cmp({nm, ".akuma_health"}, AkumaHealth, e.e_ah);
      cmp({nm, ".ko"}, ko, e.e_ko);
      cmp({nm, ".winner"}, winner, e.e_win);
   endtask

   task automatic apply(input vec_t v, input string nm);
      @(negedge vga_clk);
      frame_tick = v.tick; round_start = v.rs;
      ryu_hit = v.rh; ryu_dmg = v.rd; akuma_hit = v.ah; akuma_dmg = v.ad;
      exp_q.push_back(v);
      name_q.push_back(nm);
      @(posedge vga_clk);
      #1;
      check_out();
   endtask

   task automatic cyc(input logic tick, input logic rs, input logic rh, input int rd,
                      input logic ah, input int ad, input logic eracc, input logic eaacc,
                      input int erh, input int eah, input logic eko, input int ew, input string nm);
      apply(mk(tick, rs, rh, rd, ah, ad, eracc, eaacc, erh, eah, eko, ew), nm);
   endtask

   vec_t  tbl[7];
   string tnames[7];

   initial begin
      tbl[0] = mk(0, 0, 1, 50,  0, 0,   0, 0, 200, 200, 0, 0); tnames[0] = "idle_hit";
      tbl[1] = mk(0, 1, 0, 0,   0, 0,   0, 0, 200, 200, 0, 0); tnames[1] = "round_start";
      tbl[2] = mk(0, 0, 1, 0,   0, 0,   0, 0, 200, 200, 0, 0); tnames[2] = "zero_dmg";
      tbl[3] = mk(0, 0, 1, 50,  0, 0,   1, 0, 200, 200, 0, 0); tnames[3] = "hit50";
      tbl[4] = mk(0, 0, 0, 0,   0, 0,   0, 0, 200, 200, 0, 0); tnames[4] = "acc_one_cycle";
      tbl[5] = mk(1, 0, 0, 0,   1, 160, 0, 1, 198, 200, 0, 0); tnames[5] = "hit_with_tick";
      tbl[6] = mk(0, 0, 0, 0,   1, 10,  0, 0, 198, 200, 0, 0); tnames[6] = "akuma_inv_reject";

      #12;
      cmp("reset.ryu_health", RyuHealth, 200);
      cmp("reset.akuma_health", AkumaHealth, 200);
      cmp("reset.ko", ko, 0);
      cmp("reset.winner", winner, 0);
      cmp("reset.ryu_acc", ryu_hit_acc, 0);
      cmp("reset.akuma_acc", akuma_hit_acc, 0);
      @(negedge vga_clk);
      Reset_n = 1'b1;

      for (int i = 0; i < 7; i++) apply(tbl[i], tnames[i]);

      // Tick t is the t-th frame since the Ryu hit; Akuma's bar started moving one tick later.
      for (int t = 2; t <= 10; t++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, max2(200 - 2 * t, 150), max2(202 - 2 * t, 40), 0, 0, "drain_early");
      cyc(0, 0, 1, 20, 0, 0, 0, 0, 180, 182, 0, 0, "ryu_inv_reject_f10");
      for (int t = 11; t <= 30; t++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, max2(200 - 2 * t, 150), max2(202 - 2 * t, 40), 0, 0, "drain_settle");
      cyc(0, 0, 1, 20, 1, 255, 1, 0, 150, 142, 0, 0, "f30_accept_and_load_wins");
      for (int t = 31; t <= 81; t++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, max2(150 - 2 * (t - 30), 130), max2(202 - 2 * t, 40), 0, 0, "drain_late");

      cyc(0, 0, 0, 0, 1, 255, 0, 1, 130, 40, 0, 0, "akuma_zeroed");
      cyc(0, 0, 1, 10, 0, 0, 0, 0, 130, 40, 0, 0, "finish_ignores_hit");
      for (int k = 1; k <= 20; k++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 130, 40 - 2 * k, 0, 0, "finish_drain");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 130, 0, 1, 1, "ko_ryu_wins");
      cyc(1, 0, 1, 10, 0, 0, 0, 0, 130, 0, 1, 1, "ko_frozen");

      cyc(0, 1, 0, 0, 0, 0, 0, 0, 200, 200, 0, 0, "restart_from_ko");
      cyc(0, 0, 1, 200, 1, 200, 1, 1, 200, 200, 0, 0, "double_hit");
      for (int k = 1; k <= 100; k++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 200 - 2 * k, 200 - 2 * k, 0, 0, "double_drain");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, "ko_draw");

      cyc(0, 1, 0, 0, 0, 0, 0, 0, 200, 200, 0, 0, "restart2");
      cyc(0, 0, 1, 100, 0, 0, 1, 0, 200, 200, 0, 0, "hit100");
      for (int k = 1; k <= 5; k++)
         cyc(1, 0, 0, 0, 0, 0, 0, 0, 200 - 2 * k, 200, 0, 0, "pre_reset_drain");

      @(negedge vga_clk);
      Reset_n = 1'b0;
      #1;
      cmp("mid_reset.ryu_health", RyuHealth, 200);
      cmp("mid_reset.akuma_health", AkumaHealth, 200);
      cmp("mid_reset.ko", ko, 0);
      cmp("mid_reset.winner", winner, 0);
      @(negedge vga_clk);
      Reset_n = 1'b1;
      cyc(0, 0, 1, 50, 0, 0, 0, 0, 200, 200, 0, 0, "idle_after_reset");
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 200, 200, 0, 0, "start3");
      cyc(0, 0, 1, 50, 0, 0, 1, 0, 200, 200, 0, 0, "fight_after_start");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
